// File: rtl/keypad_scan.sv
// 4x4 matrix keypad reader: column scan, 2-FF row synchronizer, snapshot debounce,
// press/release event FIFO exposed on the strobe/rw/addr device bus.
module keypad_scan #(
  parameter int unsigned SCAN_BITS = 16,
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  input  logic [3:0]  row,
  output logic [3:0]  col
);

  localparam int unsigned CntW  = SCAN_BITS + 2;
  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE);

  logic [CntW-1:0]      scan_q, scan_d;
  logic [3:0]           col_q, col_d;
  logic [3:0]           row_s1_q, row_s2_q;
  logic [15:0]          snap_q, snap_d, cand_q, cand_d, state_q, state_d, pend_q, pend_d;
  logic [DbW-1:0]       db_q, db_d;
  logic [4:0]           mem_q [Depth];
  logic [4:0]           mem_d [Depth];
  logic [FIFO_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_LOG2:0]   fcnt_q, fcnt_d;
  logic                 ovf_q, ovf_d;

  logic [1:0]  col_idx;
  logic        sample, scan_done;
  logic [15:0] changes, low_bit;
  logic [3:0]  ev_key;
  logic        has_ev, full, empty, pop, push, drop, flush, clr_ovf;
  logic [4:0]  ev;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:2], d_in[31:2]};
  assign col         = col_q;

  // Scan counter and snapshot capture
  always_comb begin
    scan_d    = scan_q + 1'b1;
    col_d     = ~(4'b0001 << scan_d[CntW-1:SCAN_BITS]);
    col_idx   = scan_q[CntW-1:SCAN_BITS];
    sample    = &scan_q[SCAN_BITS-1:0];
    scan_done = sample && (col_idx == 2'd3);
    snap_d    = snap_q;
    if (sample) snap_d[{col_idx, 2'b00} +: 4] = ~row_s2_q;
  end

  // Debounce over full-matrix snapshots
  always_comb begin
    cand_d  = cand_q;
    db_d    = db_q;
    state_d = state_q;
    changes = '0;
    if (scan_done) begin
      if (snap_d != cand_q) begin
        cand_d = snap_d;
        db_d   = DbW'(1);
      end else if (db_q < DbMax) begin
        db_d = db_q + 1'b1;
      end
      if ((db_d == DbMax) && (cand_d != state_q)) begin
        state_d = cand_d;
        changes = state_q ^ cand_d;
      end
    end
  end

  // Event drain, FIFO and bus writes
  always_comb begin
    ev_key = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) ev_key = 4'(i);
    end
    has_ev  = |pend_q;
    low_bit = has_ev ? (16'h0001 << ev_key) : 16'h0000;
    ev      = {state_q[ev_key], ev_key};
    empty   = (fcnt_q == '0);
    full    = fcnt_q[FIFO_LOG2];
    pop     = strobe && !rw && (addr[1:0] == 2'd1) && !empty;
    push    = has_ev && (!full || pop);
    drop    = has_ev && full && !pop;
    flush   = strobe && rw && (addr[1:0] == 2'd2) && d_in[1];
    clr_ovf = strobe && rw && (addr[1:0] == 2'd2) && d_in[0];

    pend_d = flush ? 16'h0000 : ((pend_q & ~low_bit) | changes);

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      fcnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = ev;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
      else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
    end

    // A drop in the same cycle as a clear leaves the flag set
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Read mux
  always_comb begin
    d_out = '0;
    case (addr[1:0])
      2'd0:    d_out = {16'h0000, state_q};
      2'd1:    if (!empty) d_out = {1'b1, 26'b0, mem_q[rptr_q]};
      2'd2:    d_out = {ovf_q, 23'b0, 8'(fcnt_q)};
      default: d_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q   <= '0;
      col_q    <= 4'b1111;
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
      snap_q   <= '0;
      cand_q   <= '0;
      state_q  <= '0;
      pend_q   <= '0;
      db_q     <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      scan_q   <= scan_d;
      col_q    <= col_d;
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      snap_q   <= snap_d;
      cand_q   <= cand_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      db_q     <= db_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical key matrix drives the rows from col, and a
// key-level model (accepted state, event queue, overflow flag) predicts the registers.
module tb_keypad_scan;

  localparam int unsigned QDepth = 4;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic [3:0]  row;
  logic [3:0]  col;

  logic [15:0] keys;
  logic [15:0] m_state;
  logic [4:0]  m_q[$];
  logic        m_ovf;
  int          n_checks;
  int          n_fail;

  keypad_scan #(
    .SCAN_BITS(2),
    .DEBOUNCE (2),
    .FIFO_LOG2(2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .strobe(strobe),
    .rw    (rw),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out),
    .row   (row),
    .col   (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] data);
    @(negedge clk);
    strobe = 1'b0;
    addr   = {30'b0, a};
    #1 data = d_out;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    strobe = 1'b1;
    rw     = 1'b1;
    addr   = {30'b0, a};
    d_in   = d;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    rw     = 1'b0;
    d_in   = '0;
  endtask

  task automatic model_write2(input logic [31:0] d);
    bus_write(2'd2, d);
    if (d[0]) m_ovf = 1'b0;
    if (d[1]) m_q.delete();
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] got, exp;
    @(negedge clk);
    strobe = 1'b1;
    rw     = 1'b0;
    addr   = 32'd1;
    #1 got = d_out;
    exp = (m_q.size() == 0) ? 32'h0 : {1'b1, 26'b0, m_q[0]};
    check_eq(tag, got, exp);
    @(posedge clk);
    #1 strobe = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] got;
    peek(2'd0, got);
    check_eq({tag, "_reg0"}, got, {16'h0, m_state});
    peek(2'd2, got);
    check_eq({tag, "_reg2"}, got, {m_ovf, 23'b0, 8'(m_q.size())});
  endtask

  // Hold keys long enough for two clean snapshots and the drain, then apply the key-level rule
  task automatic settle();
    logic [15:0] diff;
    repeat (100) @(posedge clk);
    diff = m_state ^ keys;
    for (int k = 0; k < 16; k++) begin
      if (diff[k]) begin
        if (m_q.size() < QDepth) m_q.push_back({keys[k], 4'(k)});
        else m_ovf = 1'b1;
      end
    end
    m_state = keys;
  endtask

  task automatic set_keys(input logic [15:0] k);
    @(negedge clk);
    keys = k;
  endtask

  task automatic drain_all(input string tag);
    while (m_q.size() != 0) pop_check(tag);
    pop_check({tag, "_empty"});
  endtask

  initial begin
    logic [31:0] got;
    logic [3:0]  seen [40];
    logic [3:0]  exp4;
    logic [15:0] mask;
    int          start;
    logic        drain_seen;

    n_checks = 0;
    n_fail   = 0;
    keys     = '0;
    m_state  = '0;
    m_ovf    = 1'b0;
    strobe   = 1'b0;
    rw       = 1'b0;
    addr     = '0;
    d_in     = '0;
    rst_n    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_col", {28'b0, col}, 32'hF);
    check_eq("reset_reg0", d_out, 32'h0);
    rst_n = 1'b1;

    // Column rotation: one low column, 4 clocks each
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen[i] = col;
    end
    start = -1;
    for (int i = 1; i < 10; i++) begin
      if (start < 0 && seen[i] == 4'b1101 && seen[i-1] == 4'b1110) start = i;
    end
    check_eq("col_phase_found", {31'b0, start >= 0}, 32'h1);
    if (start >= 0) begin
      for (int j = 0; j < 16; j++) begin
        exp4 = 4'b0001 << ((j / 4 + 1) % 4);
        exp4 = ~exp4;
        check_eq("col_seq", {28'b0, seen[start+j]}, {28'b0, exp4});
      end
    end
    check_regs("idle");

    // Key 9 (column 2, row 1)
    set_keys(16'h0200);
    settle();
    check_regs("key9");
    peek(2'd1, got);
    check_eq("key9_head", got, 32'h8000_0019);
    pop_check("key9_pop");
    check_regs("key9_after_pop");
    set_keys(16'h0000);
    settle();
    peek(2'd1, got);
    check_eq("key9_release_head", got, 32'h8000_0009);
    drain_all("key9_release");

    // Short glitch must not change state
    set_keys(16'h0040);
    repeat (10) @(negedge clk);
    keys = 16'h0000;
    settle();
    check_regs("glitch");

    // Keys 0, 5, 15 together
    set_keys(16'h8021);
    settle();
    check_regs("multi");
    peek(2'd0, got);
    check_eq("multi_state", got, 32'h0000_8021);
    drain_all("multi_ev");
    set_keys(16'h0000);
    settle();
    drain_all("multi_rel");

    // Overflow with six presses, then flush and clear
    set_keys(16'h2C1A);
    settle();
    check_regs("ovf");
    peek(2'd2, got);
    check_eq("ovf_reg2", got, 32'h8000_0004);
    model_write2(32'h2);
    peek(2'd2, got);
    check_eq("flush_reg2", got, 32'h8000_0000);
    model_write2(32'h1);
    peek(2'd2, got);
    check_eq("clear_reg2", got, 32'h0);
    set_keys(16'h0000);
    settle();
    check_regs("ovf_release");
    drain_all("ovf_release");
    model_write2(32'h3);

    // Reset in the middle of a drain
    set_keys(16'h1084);
    drain_seen = 1'b0;
    for (int t = 0; t < 200 && !drain_seen; t++) begin
      peek(2'd2, got);
      if (got[7:0] != 8'h0) drain_seen = 1'b1;
    end
    check_eq("drain_seen", {31'b0, drain_seen}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_col", {28'b0, col}, 32'hF);
    peek(2'd0, got);
    check_eq("midreset_reg0", got, 32'h0);
    peek(2'd1, got);
    check_eq("midreset_reg1", got, 32'h0);
    peek(2'd2, got);
    check_eq("midreset_reg2", got, 32'h0);
    rst_n = 1'b1;
    m_state = '0;
    m_q.delete();
    m_ovf = 1'b0;
    repeat (5) @(posedge clk);
    peek(2'd0, got);
    check_eq("postreset_reg0", got, 32'h0);
    settle();
    check_regs("postreset");
    drain_all("postreset");

    // Randomized sequence
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          mask = 16'h0001 << $urandom_range(0, 15);
          if ($urandom_range(0, 1) == 1) mask |= 16'h0001 << $urandom_range(0, 15);
          set_keys(keys ^ mask);
          settle();
        end
        2: begin
          mask = 16'($urandom_range(1, 16'hFFFF));
          set_keys(keys ^ mask);
          repeat ($urandom_range(1, 12)) @(negedge clk);
          keys = keys ^ mask;
          settle();
        end
        3: begin
          repeat ($urandom_range(1, 3)) pop_check("rand_pop");
        end
        4: begin
          model_write2({30'b0, 2'($urandom_range(0, 3))});
        end
        default: begin
          bus_write(2'd0, $urandom);
          bus_write(2'd1, $urandom);
          bus_write(2'd3, $urandom);
          peek(2'd3, got);
          check_eq("rand_reg3", got, 32'h0);
        end
      endcase
      check_regs("rand");
    end
    drain_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
